// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Controller state.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        HALTED   = 2'd3
    } hz_state_t;

    // Action chosen for the current cycle after priority resolution.
    typedef enum logic [3:0] {
        ACT_IDLE    = 4'd0,
        ACT_HALTED  = 4'd1,
        ACT_HALT    = 4'd2,
        ACT_WAIT    = 4'd3,
        ACT_RELEASE = 4'd4,
        ACT_FLUSH   = 4'd5,
        ACT_LU      = 4'd6,
        ACT_JUMP    = 4'd7,
        ACT_IMISS   = 4'd8
    } hz_act_t;

    // Pipeline latch indices into flush/freeze.
    localparam int IFID  = 0;
    localparam int IDEX  = 1;
    localparam int EXMEM = 2;
    localparam int MEMWB = 3;

    // Width of the remaining-bubble counter (at most 2 extra bubbles).
    localparam int BUB_W = 2;

endpackage : hazard_pkg

// File: rtl/hazard_perf_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualified events, saturating at the maximum value.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : hazard_perf_counter

// File: rtl/hazard_ctrl_unit.sv
// Stateful pipeline hazard controller: load-use bubbles, dcache-miss wait,
// deferred mispredict flush, sticky halt and saturating perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NSTAGES    = 5,
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [REG_W-1:0]   rs_id,
    input  logic [REG_W-1:0]   rt_id,
    input  logic               rs_used,
    input  logic               rt_used,
    input  logic               memread_ex,
    input  logic [REG_W-1:0]   rd_ex,
    input  logic               jump_id,
    input  logic               mispredict_ex,
    input  logic               ihit,
    input  logic               dmem_req,
    input  logic               dhit,
    input  logic               halt_wb,
    output logic [NSTAGES-2:0] flush,
    output logic [NSTAGES-2:0] freeze,
    output logic               pc_en,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int L = NSTAGES - 1;

    hz_state_t          state;
    hz_state_t          state_nxt;
    logic [BUB_W-1:0]   bub_cnt;
    logic [BUB_W-1:0]   bub_nxt;
    logic               pend_flush;
    logic               pend_nxt;
    hz_act_t            act;
    logic               hz;
    logic [L-1:0]       flush_raw;
    logic [L-1:0]       freeze_int;
    logic               flush_evt;
    logic               stall_inc;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    assign hz = memread_ex && (rd_ex != '0) &&
                ((rs_used && (rs_id == rd_ex)) || (rt_used && (rt_id == rd_ex)));

    // Resolve this cycle's action in priority order.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        act = ACT_IDLE;
        if (state == HALTED) begin
            act = ACT_HALTED;
        end else if (halt_wb) begin
            act = ACT_HALT;
        end else if (state == MEM_WAIT) begin
            act = dhit ? ACT_RELEASE : ACT_WAIT;
        end else if (dmem_req && !dhit) begin
            act = ACT_WAIT;
        end else if (pend_flush || mispredict_ex) begin
            act = ACT_FLUSH;
        end else if ((state == LU_STALL) || hz) begin
            act = ACT_LU;
        end else if (jump_id) begin
            act = ACT_JUMP;
        end else if (!ihit) begin
            act = ACT_IMISS;
        end
    end

    // State register with remaining-bubble count and deferred flush flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            bub_cnt    <= '0;
            pend_flush <= 1'b0;
        end else begin
            state      <= state_nxt;
            bub_cnt    <= bub_nxt;
            pend_flush <= pend_nxt;
        end
    end

    // Next-state logic driven by the resolved action.
    always_comb begin
        state_nxt = state;
        bub_nxt   = bub_cnt;
        pend_nxt  = pend_flush;
        case (act)
            ACT_HALTED, ACT_HALT: begin
                state_nxt = HALTED;
            end
            ACT_WAIT: begin
                // A mispredict seen while the pipe is held is replayed once released.
                state_nxt = MEM_WAIT;
                if (mispredict_ex) pend_nxt = 1'b1;
            end
            ACT_RELEASE: begin
                // Resume an interrupted load-use stall; bub_cnt was left untouched.
                state_nxt = (bub_cnt != '0) ? LU_STALL : RUN;
                if (mispredict_ex) pend_nxt = 1'b1;
            end
            ACT_FLUSH: begin
                state_nxt = RUN;
                bub_nxt   = '0;
                pend_nxt  = 1'b0;
            end
            ACT_LU: begin
                if (state == LU_STALL) begin
                    bub_nxt   = bub_cnt - BUB_W'(1);
                    state_nxt = (bub_cnt == BUB_W'(1)) ? RUN : LU_STALL;
                end else if (LU_BUBBLES > 1) begin
                    bub_nxt   = BUB_W'(LU_BUBBLES - 1);
                    state_nxt = LU_STALL;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    // Output decode: per-latch flush/freeze, PC enable and event strobes.
    always_comb begin
        flush_raw  = '0;
        freeze_int = '0;
        pc_en      = 1'b1;
        flush_evt  = 1'b0;
        case (act)
            ACT_HALTED, ACT_HALT, ACT_WAIT: begin
                freeze_int = '1;
                pc_en      = 1'b0;
            end
            ACT_FLUSH: begin
                flush_raw[IFID] = 1'b1;
                flush_raw[IDEX] = 1'b1;
                flush_evt       = 1'b1;
            end
            ACT_LU: begin
                freeze_int[IFID] = 1'b1;
                flush_raw[IDEX]  = 1'b1;
                pc_en            = 1'b0;
            end
            ACT_JUMP: begin
                flush_raw[IFID] = 1'b1;
                flush_evt       = 1'b1;
            end
            ACT_IMISS: begin
                flush_raw[IFID] = 1'b1;
                pc_en           = 1'b0;
            end
            default: begin
                pc_en = 1'b1;
            end
        endcase
    end

    // A held latch is never cleared in the same cycle.
    assign freeze    = freeze_int;
    assign flush     = flush_raw & ~freeze_int;
    assign halted    = (state == HALTED);
    assign stall_inc = !pc_en && (state != HALTED);

    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush_evt),
        .count (flush_cnt)
    );

endmodule : hazard_ctrl_unit

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LU_BUBBLES 1/2/3, the last with
// 4-bit counters) share one stimulus stream and a behavioural model each.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_id, rt_id, rd_ex;
    logic       rs_used, rt_used, memread_ex, jump_id, mispredict_ex;
    logic       ihit, dmem_req, dhit, halt_wb;

    logic [3:0]  flush0, flush1, flush2, freeze0, freeze1, freeze2;
    logic        pc_en0, pc_en1, pc_en2, halted0, halted1, halted2;
    logic [31:0] stall0, stall1, fcnt0, fcnt1;
    logic [3:0]  stall2, fcnt2;

    logic [3:0]  flush_v [3];
    logic [3:0]  freeze_v[3];
    logic        pc_v    [3];
    logic        halted_v[3];
    logic [31:0] stall_v [3];
    logic [31:0] fcnt_v  [3];

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state, one slot per instance.
    bit          m_halted[3];
    bit          m_wait  [3];
    bit          m_pend  [3];
    int          m_owed  [3];
    logic [31:0] m_stall [3];
    logic [31:0] m_fcnt  [3];
    int          m_lu    [3] = '{1, 2, 3};
    logic [31:0] m_max   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.LU_BUBBLES(1), .CNT_W(32)) u_lu1 (
        .CLK(clk), .RST(rst), .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .memread_ex(memread_ex), .rd_ex(rd_ex), .jump_id(jump_id), .mispredict_ex(mispredict_ex),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit), .halt_wb(halt_wb),
        .flush(flush0), .freeze(freeze0), .pc_en(pc_en0), .halted(halted0),
        .stall_cnt(stall0), .flush_cnt(fcnt0)
    );

    hazard_ctrl_unit #(.LU_BUBBLES(2), .CNT_W(32)) u_lu2 (
        .CLK(clk), .RST(rst), .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .memread_ex(memread_ex), .rd_ex(rd_ex), .jump_id(jump_id), .mispredict_ex(mispredict_ex),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit), .halt_wb(halt_wb),
        .flush(flush1), .freeze(freeze1), .pc_en(pc_en1), .halted(halted1),
        .stall_cnt(stall1), .flush_cnt(fcnt1)
    );

    hazard_ctrl_unit #(.LU_BUBBLES(3), .CNT_W(4)) u_lu3 (
        .CLK(clk), .RST(rst), .rs_id(rs_id), .rt_id(rt_id), .rs_used(rs_used), .rt_used(rt_used),
        .memread_ex(memread_ex), .rd_ex(rd_ex), .jump_id(jump_id), .mispredict_ex(mispredict_ex),
        .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit), .halt_wb(halt_wb),
        .flush(flush2), .freeze(freeze2), .pc_en(pc_en2), .halted(halted2),
        .stall_cnt(stall2), .flush_cnt(fcnt2)
    );

    // Gather instance outputs into indexable views.
    always_comb begin
        flush_v[0]  = flush0;  flush_v[1]  = flush1;  flush_v[2]  = flush2;
        freeze_v[0] = freeze0; freeze_v[1] = freeze1; freeze_v[2] = freeze2;
        pc_v[0]     = pc_en0;  pc_v[1]     = pc_en1;  pc_v[2]     = pc_en2;
        halted_v[0] = halted0; halted_v[1] = halted1; halted_v[2] = halted2;
        stall_v[0]  = stall0;  stall_v[1]  = stall1;  stall_v[2]  = {28'd0, stall2};
        fcnt_v[0]   = fcnt0;   fcnt_v[1]   = fcnt1;   fcnt_v[2]   = {28'd0, fcnt2};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle of the reference model for instance k: compare, then advance.
    task automatic model_step(input int k);
        logic [3:0] e_fl, e_fz;
        logic       e_pc;
        bit         hz, miss, fevt;
        if (rst) begin
            m_halted[k] = 0; m_wait[k] = 0; m_pend[k] = 0; m_owed[k] = 0;
            m_stall[k]  = 0; m_fcnt[k] = 0;
            return;
        end
        check($sformatf("stall_cnt[%0d]", k), stall_v[k], m_stall[k]);
        check($sformatf("flush_cnt[%0d]", k), fcnt_v[k], m_fcnt[k]);
        check($sformatf("halted[%0d]", k), {31'd0, halted_v[k]}, {31'd0, m_halted[k]});

        hz   = memread_ex && rd_ex != 0 &&
               ((rs_used && rs_id == rd_ex) || (rt_used && rt_id == rd_ex));
        miss = dmem_req && !dhit;
        e_fl = 4'b0000; e_fz = 4'b0000; e_pc = 1'b1; fevt = 0;

        if (m_halted[k]) begin
            e_fz = 4'b1111; e_pc = 0;
        end else if (halt_wb) begin
            e_fz = 4'b1111; e_pc = 0;
        end else if (m_wait[k] || miss) begin
            if (mispredict_ex) m_pend[k] = 1;
            if (!(m_wait[k] && dhit)) begin
                e_fz = 4'b1111; e_pc = 0;
            end
        end else if (m_pend[k] || mispredict_ex) begin
            e_fl = 4'b0011; fevt = 1;
        end else if (hz || m_owed[k] > 0) begin
            e_fz = 4'b0001; e_fl = 4'b0010; e_pc = 0;
        end else if (jump_id) begin
            e_fl = 4'b0001; fevt = 1;
        end else if (!ihit) begin
            e_fl = 4'b0001; e_pc = 0;
        end

        check($sformatf("flush[%0d]", k), {28'd0, flush_v[k]}, {28'd0, e_fl});
        check($sformatf("freeze[%0d]", k), {28'd0, freeze_v[k]}, {28'd0, e_fz});
        check($sformatf("pc_en[%0d]", k), {31'd0, pc_v[k]}, {31'd0, e_pc});

        // Advance the model as the coming clock edge will.
        if (!e_pc && !m_halted[k] && m_stall[k] != m_max[k]) m_stall[k]++;
        if (fevt && m_fcnt[k] != m_max[k]) m_fcnt[k]++;
        if (m_halted[k]) begin
            // stays halted
        end else if (halt_wb) begin
            m_halted[k] = 1;
        end else if (m_wait[k] || miss) begin
            m_wait[k] = !(m_wait[k] && dhit);
        end else if (m_pend[k] || mispredict_ex) begin
            m_pend[k] = 0; m_owed[k] = 0;
        end else if (m_owed[k] > 0) begin
            m_owed[k]--;
        end else if (hz) begin
            m_owed[k] = m_lu[k] - 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_id = 0; rt_id = 0; rd_ex = 0; rs_used = 0; rt_used = 0;
        memread_ex = 0; jump_id = 0; mispredict_ex = 0;
        ihit = 1; dmem_req = 0; dhit = 1; halt_wb = 0;
    endtask

    task automatic randomize_inputs();
        rs_id         = 5'($urandom_range(0, 3));
        rt_id         = 5'($urandom_range(0, 3));
        rd_ex         = 5'($urandom_range(0, 3));
        rs_used       = $urandom_range(0, 1) == 1;
        rt_used       = $urandom_range(0, 1) == 1;
        memread_ex    = $urandom_range(0, 2) == 0;
        jump_id       = $urandom_range(0, 9) == 0;
        mispredict_ex = $urandom_range(0, 9) == 0;
        ihit          = $urandom_range(0, 6) != 0;
        dmem_req      = $urandom_range(0, 2) == 0;
        dhit          = $urandom_range(0, 4) < 3;
        halt_wb       = $urandom_range(0, 399) == 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;

        // Reset values.
        #1;
        check("rst_flush", {28'd0, flush0}, 32'h0);
        check("rst_freeze", {28'd0, freeze0}, 32'h0);
        check("rst_pc_en", {31'd0, pc_en0}, 32'h1);
        check("rst_stall_cnt", stall0, 32'h0);
        cycle();

        // Load-use hazard: 1, 2 and 3 stall cycles depending on LU_BUBBLES.
        memread_ex = 1; rd_ex = 5; rs_id = 5; rs_used = 1;
        #1;
        check("lu_freeze", {28'd0, freeze0}, 32'h1);
        check("lu_flush", {28'd0, flush0}, 32'h2);
        check("lu_pc_en", {31'd0, pc_en0}, 32'h0);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) cycle();
        check("lu1_stalls", stall0, 32'd1);
        check("lu2_stalls", stall1, 32'd2);
        check("lu3_stalls", {28'd0, stall2}, 32'd3);
        // rd_ex = 0 never stalls.
        memread_ex = 1; rd_ex = 0; rs_id = 0; rs_used = 1;
        #1;
        check("r0_pc_en", {31'd0, pc_en0}, 32'h1);
        cycle();
        idle();
        cycle();
        check("r0_stalls", stall1, 32'd2);

        // Dcache miss for 3 cycles with a mispredict in the middle.
        do_reset();
        dmem_req = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            mispredict_ex = (i == 1);
            #1;
            check("miss_freeze", {28'd0, freeze0}, 32'hF);
            cycle();
        end
        mispredict_ex = 0; dhit = 1;
        #1;
        check("rel_freeze", {28'd0, freeze0}, 32'h0);
        check("rel_pc_en", {31'd0, pc_en0}, 32'h1);
        cycle();
        idle();
        #1;
        check("pend_flush", {28'd0, flush0}, 32'h3);
        cycle();
        check("pend_flush_cnt", fcnt0, 32'd1);
        check("miss_stall_cnt", stall0, 32'd3);

        // Mispredict aborts an in-flight LU_STALL (LU_BUBBLES=3).
        do_reset();
        memread_ex = 1; rd_ex = 7; rt_id = 7; rt_used = 1;
        cycle();
        idle();
        mispredict_ex = 1;
        #1;
        check("abort_flush", {28'd0, flush2}, 32'h3);
        check("abort_pc_en", {31'd0, pc_en2}, 32'h1);
        cycle();
        idle();
        #1;
        check("abort_run_pc", {31'd0, pc_en2}, 32'h1);
        check("abort_run_frz", {28'd0, freeze2}, 32'h0);
        cycle();

        // Sticky halt survives toggling inputs.
        do_reset();
        halt_wb = 1;
        cycle();
        for (int i = 0; i < 10; i++) begin
            randomize_inputs();
            #1;
            check("halt_freeze", {28'd0, freeze1}, 32'hF);
            check("halt_pc_en", {31'd0, pc_en1}, 32'h0);
            cycle();
        end
        check("halted", {31'd0, halted1}, 32'h1);
        check("halt_stall_cnt", stall1, 32'd1);

        // Reset in the middle of MEM_WAIT.
        do_reset();
        dmem_req = 1; dhit = 0;
        cycle();
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        idle();
        #1;
        check("mwrst_flush", {28'd0, flush0}, 32'h0);
        check("mwrst_freeze", {28'd0, freeze0}, 32'h0);
        check("mwrst_pc_en", {31'd0, pc_en0}, 32'h1);
        check("mwrst_stall", stall0, 32'h0);
        check("mwrst_fcnt", fcnt0, 32'h0);
        cycle();

        // Saturation of the 4-bit counters.
        do_reset();
        ihit = 0;
        for (int i = 0; i < 20; i++) cycle();
        idle();
        jump_id = 1;
        for (int i = 0; i < 20; i++) cycle();
        idle();
        cycle();
        check("sat_stall", {28'd0, stall2}, 32'hF);
        check("sat_fcnt", {28'd0, fcnt2}, 32'hF);
        check("nosat_stall", stall0, 32'd20);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            rst = $urandom_range(0, 149) == 0;
            cycle();
        end
        rst = 0;
        idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_hazard_ctrl_unit
